// File: rtl/seq_controller_if.sv
// Instruction/control bundle between an instruction source and seq_controller.
// The master side issues instructions and status; the slave side drives datapath controls.
interface seq_controller_if #(
    parameter int DATA_W   = 10,
    parameter int NUM_REGS = 4
);
    localparam int RA_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_W-1:0] inst_in;
    logic              inst_valid;
    logic              inst_ready;
    logic              ext_valid;
    logic              alu_done;
    logic [DATA_W-1:0] IMM;
    logic              Iout;
    logic [RA_W-1:0]   Rin;
    logic [RA_W-1:0]   Rout;
    logic              ENW;
    logic              ENR;
    logic              Ain;
    logic              Gin;
    logic              Gout;
    logic [3:0]        ALUcont;
    logic              Ext;
    logic              alu_start;
    logic [1:0]        T;
    logic              halted;
    logic              err;

    modport master (
        output inst_in, inst_valid, ext_valid, alu_done,
        input  inst_ready, IMM, Iout, Rin, Rout, ENW, ENR, Ain, Gin, Gout,
               ALUcont, Ext, alu_start, T, halted, err
    );

    modport slave (
        input  inst_in, inst_valid, ext_valid, alu_done,
        output inst_ready, IMM, Iout, Rin, Rout, ENW, ENR, Ain, Gin, Gout,
               ALUcont, Ext, alu_start, T, halted, err
    );
endinterface

// File: rtl/seq_controller.sv
// Self-sequencing processor controller: owns the IR and timestep FSM and decodes
// datapath enables from state+IR, with a bounded wait for multi-cycle ALU ops.
module seq_controller #(
    parameter int DATA_W       = 10,
    parameter int NUM_REGS     = 4,
    parameter int MULT_TIMEOUT = 15
) (
    input logic            clk,
    input logic            rst_n,
    seq_controller_if.slave bus
);
    localparam int RA_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = $clog2(MULT_TIMEOUT + 1);

    localparam logic [3:0] OP_LOAD = 4'h0, OP_COPY = 4'h1, OP_MULT = 4'h4,
                           OP_INV  = 4'h5, OP_FLP  = 4'h6, OP_ADDI = 4'hA,
                           OP_SUBI = 4'hB, OP_SHL  = 4'hC, OP_SHR  = 4'hD,
                           OP_NOP  = 4'hE, OP_HALT = 4'hF;

    typedef enum logic [2:0] {FETCH, T1, T2, T3, WAIT, HALTED} state_e;

    state_e            state;
    logic [DATA_W-1:0] ir;
    logic [CNT_W-1:0]  wait_cnt;
    logic              err_q;

    logic [3:0]      op;
    logic [RA_W-1:0] rx, ry;
    assign op = ir[3:0];
    assign rx = ir[4 +: RA_W];
    assign ry = ir[4+RA_W +: RA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            ir       <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                FETCH: if (bus.inst_valid) begin
                    ir    <= bus.inst_in;
                    state <= T1;
                end
                T1: case (op)
                    OP_LOAD:         if (bus.ext_valid) state <= FETCH;
                    OP_COPY, OP_NOP: state <= FETCH;
                    OP_HALT:         state <= HALTED;
                    default:         state <= T2;
                endcase
                T2: begin
                    wait_cnt <= '0;
                    state    <= (op == OP_MULT) ? WAIT : T3;
                end
                // Timeout abandons the op entirely: no writeback, error is sticky.
                WAIT: if (bus.alu_done) begin
                    state <= T3;
                end else if (wait_cnt == CNT_W'(MULT_TIMEOUT - 1)) begin
                    err_q <= 1'b1;
                    state <= FETCH;
                end else begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
                T3:      state <= FETCH;
                HALTED:  state <= HALTED;
                default: state <= FETCH;
            endcase
        end
    end

    assign bus.IMM        = ir >> (4 + RA_W);
    assign bus.err        = err_q;
    assign bus.inst_ready = (state == FETCH);
    assign bus.halted     = (state == HALTED);

    always_comb begin
        bus.Iout      = 1'b0;
        bus.Rin       = '0;
        bus.Rout      = '0;
        bus.ENW       = 1'b0;
        bus.ENR       = 1'b0;
        bus.Ain       = 1'b0;
        bus.Gin       = 1'b0;
        bus.Gout      = 1'b0;
        bus.ALUcont   = 4'h0;
        bus.Ext       = 1'b0;
        bus.alu_start = 1'b0;
        bus.T         = 2'd0;
        case (state)
            T1: begin
                bus.T = 2'd1;
                case (op)
                    OP_LOAD: if (bus.ext_valid) begin
                        bus.Ext = 1'b1;
                        bus.ENW = 1'b1;
                        bus.Rin = rx;
                    end
                    OP_COPY: begin
                        bus.ENR  = 1'b1;
                        bus.Rout = ry;
                        bus.ENW  = 1'b1;
                        bus.Rin  = rx;
                    end
                    OP_NOP, OP_HALT: ;
                    default: begin
                        bus.ENR  = 1'b1;
                        bus.Rout = rx;
                        bus.Ain  = 1'b1;
                    end
                endcase
            end
            T2: begin
                bus.T = 2'd2;
                case (op)
                    OP_MULT: begin
                        bus.ENR       = 1'b1;
                        bus.Rout      = ry;
                        bus.ALUcont   = OP_MULT;
                        bus.alu_start = 1'b1;
                    end
                    OP_INV, OP_FLP, OP_SHL, OP_SHR: begin
                        bus.Gin     = 1'b1;
                        bus.ALUcont = op;
                    end
                    // Immediate forms reuse the ADD/SUB ALU encodings.
                    OP_ADDI, OP_SUBI: begin
                        bus.Iout    = 1'b1;
                        bus.Gin     = 1'b1;
                        bus.ALUcont = (op == OP_ADDI) ? 4'h2 : 4'h3;
                    end
                    default: begin
                        bus.ENR     = 1'b1;
                        bus.Rout    = ry;
                        bus.Gin     = 1'b1;
                        bus.ALUcont = op;
                    end
                endcase
            end
            WAIT: begin
                bus.T       = 2'd3;
                bus.ALUcont = OP_MULT;
                bus.Gin     = bus.alu_done;
            end
            T3: begin
                bus.T    = 2'd3;
                bus.Gout = 1'b1;
                bus.ENW  = 1'b1;
                bus.Rin  = rx;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_seq_controller.sv
// Bench for seq_controller: directed scenarios plus randomized traffic, all cycles
// checked against a micro-op program model of each instruction.
module tb_seq_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    seq_controller_if #(.DATA_W(10), .NUM_REGS(4)) bus ();

    seq_controller #(.DATA_W(10), .NUM_REGS(4), .MULT_TIMEOUT(15)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Each instruction expands into a list of per-cycle micro-steps; blocking steps
    // (external data, multiplier wait, halt) stay at the head until released.
    typedef enum {S_LDW, S_COPY, S_NOP, S_RDA, S_RDB, S_UN, S_IMM, S_MST, S_MW, S_WB, S_HLT} step_e;
    step_e      prog[$];
    logic [9:0] m_ir = '0;
    logic       m_err = 1'b0;
    int         wcnt = 0;

    function automatic void load_prog(input logic [3:0] op);
        prog.delete();
        case (op)
            4'h0: prog = '{S_LDW};
            4'h1: prog = '{S_COPY};
            4'hE: prog = '{S_NOP};
            4'hF: prog = '{S_NOP, S_HLT};
            4'h4: prog = '{S_RDA, S_MST, S_MW, S_WB};
            4'h5, 4'h6, 4'hC, 4'hD: prog = '{S_RDA, S_UN, S_WB};
            4'hA, 4'hB: prog = '{S_RDA, S_IMM, S_WB};
            default: prog = '{S_RDA, S_RDB, S_WB};
        endcase
    endfunction

    always @(negedge clk) begin : model
        logic e_rdy, e_io, e_enw, e_enr, e_ain, e_gin, e_gout, e_ext, e_st, e_hlt;
        logic [1:0]  e_rin, e_rout, e_t, rx, ry;
        logic [3:0]  e_alu, op;
        logic [31:0] act, exp;
        {e_rdy, e_io, e_enw, e_enr, e_ain, e_gin, e_gout, e_ext, e_st, e_hlt} = '0;
        e_rin = 0; e_rout = 0; e_t = 0; e_alu = 0;
        if (!rst_n) begin
            prog.delete();
            m_ir = '0; m_err = 1'b0; wcnt = 0;
        end
        op = m_ir[3:0]; rx = m_ir[5:4]; ry = m_ir[7:6];
        if (prog.size() == 0) e_rdy = 1'b1;
        else case (prog[0])
            S_LDW:  begin e_t = 1; if (bus.ext_valid) begin e_ext = 1; e_enw = 1; e_rin = rx; end end
            S_COPY: begin e_t = 1; e_enr = 1; e_rout = ry; e_enw = 1; e_rin = rx; end
            S_NOP:  e_t = 1;
            S_RDA:  begin e_t = 1; e_enr = 1; e_rout = rx; e_ain = 1; end
            S_RDB:  begin e_t = 2; e_enr = 1; e_rout = ry; e_gin = 1; e_alu = op; end
            S_UN:   begin e_t = 2; e_gin = 1; e_alu = op; end
            S_IMM:  begin e_t = 2; e_io = 1; e_gin = 1; e_alu = (op == 4'hA) ? 4'd2 : 4'd3; end
            S_MST:  begin e_t = 2; e_enr = 1; e_rout = ry; e_alu = 4; e_st = 1; end
            S_MW:   begin e_t = 3; e_alu = 4; e_gin = bus.alu_done; end
            S_WB:   begin e_t = 3; e_gout = 1; e_enw = 1; e_rin = rx; end
            S_HLT:  e_hlt = 1;
            default: ;
        endcase
        exp = {1'b0, e_rdy, m_ir / 10'd64, e_io, e_rin, e_rout, e_enw, e_enr, e_ain, e_gin,
               e_gout, e_alu, e_ext, e_st, e_t, e_hlt, m_err};
        act = {1'b0, bus.inst_ready, bus.IMM, bus.Iout, bus.Rin, bus.Rout, bus.ENW, bus.ENR,
               bus.Ain, bus.Gin, bus.Gout, bus.ALUcont, bus.Ext, bus.alu_start, bus.T,
               bus.halted, bus.err};
        chk($sformatf("cycle@%0t", $time), act, exp);
        if (rst_n) begin
            if (prog.size() == 0) begin
                if (bus.inst_valid) begin
                    m_ir = bus.inst_in;
                    load_prog(bus.inst_in[3:0]);
                    wcnt = 0;
                end
            end else case (prog[0])
                S_LDW: if (bus.ext_valid) void'(prog.pop_front());
                S_HLT: ;
                S_MW: if (bus.alu_done) void'(prog.pop_front());
                      else begin
                          wcnt++;
                          if (wcnt == 15) begin prog.delete(); m_err = 1'b1; end
                      end
                default: void'(prog.pop_front());
            endcase
        end
    end

    task automatic neg1();
        @(negedge clk); #1;
    endtask

    // Present an instruction; it is accepted on the next edge (controller is idle).
    task automatic issue(input logic [9:0] inst, input bit hold);
        @(posedge clk); #1;
        bus.inst_in = inst; bus.inst_valid = 1'b1;
        neg1();
        chk("issue_ready", 32'(bus.inst_ready), 32'd1);
        @(posedge clk); #1;
        if (!hold) bus.inst_valid = 1'b0;
    endtask

    initial begin
        int n_wait, n_start, dur;
        bit enw_seen;
        int hcnt, done_pct;
        bus.inst_in = '0; bus.inst_valid = 1'b0; bus.ext_valid = 1'b0; bus.alu_done = 1'b0;

        repeat (2) @(posedge clk);
        neg1();
        chk("rst_ready", 32'(bus.inst_ready), 32'd1);
        chk("rst_T", 32'(bus.T), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;

        // ADD R1,R2
        issue(10'h092, 1'b0);
        neg1();
        chk("add_t1", {bus.T, bus.Rout, bus.Ain, bus.ENR}, {2'd1, 2'd1, 1'b1, 1'b1});
        neg1();
        chk("add_t2", {bus.T, bus.Rout, bus.Gin, bus.ALUcont}, {2'd2, 2'd2, 1'b1, 4'd2});
        neg1();
        chk("add_t3", {bus.T, bus.Gout, bus.ENW, bus.Rin}, {2'd3, 1'b1, 1'b1, 2'd1});
        neg1();
        chk("add_next_ready", 32'(bus.inst_ready), 32'd1);

        // ADDI R3,#5
        issue(10'h17A, 1'b0);
        neg1();
        neg1();
        chk("addi_t2", {bus.Iout, bus.IMM, bus.ENR, bus.ALUcont}, {1'b1, 10'd5, 1'b0, 4'd2});
        neg1();
        chk("addi_t3", {bus.ENW, bus.Rin}, {1'b1, 2'd3});

        // MULT R0,R1 with done on the fourth WAIT cycle
        issue(10'h044, 1'b0);
        neg1();
        neg1();
        chk("mult_start", {bus.T, bus.alu_start, bus.Gin, bus.ALUcont}, {2'd2, 1'b1, 1'b0, 4'd4});
        n_start = 0;
        for (int i = 0; i < 3; i++) begin
            neg1();
            n_start += int'(bus.alu_start);
            chk("mult_wait", {bus.T, bus.Gin}, {2'd3, 1'b0});
        end
        @(posedge clk); #1 bus.alu_done = 1'b1;
        neg1();
        chk("mult_done_gin", {bus.Gin, bus.ENW}, {1'b1, 1'b0});
        @(posedge clk); #1 bus.alu_done = 1'b0;
        neg1();
        chk("mult_wb", {bus.T, bus.ENW, bus.Rin, bus.Gout}, {2'd3, 1'b1, 2'd0, 1'b1});
        chk("mult_one_pulse", 32'(n_start), 32'd0);

        // MULT timeout
        issue(10'h044, 1'b0);
        neg1();
        neg1();
        n_wait = 0; enw_seen = 0;
        for (int i = 0; i < 40 && !bus.inst_ready; i++) begin
            neg1();
            if (bus.T == 2'd3) n_wait++;
            if (bus.ENW) enw_seen = 1;
        end
        chk("mult_to_cycles", 32'(n_wait), 32'd15);
        chk("mult_to_err", {bus.err, enw_seen, bus.inst_ready}, {1'b1, 1'b0, 1'b1});

        // LOAD R2 with delayed external data
        issue(10'h020, 1'b0);
        for (int i = 0; i < 4; i++) begin
            neg1();
            chk("load_hold", {bus.T, bus.Ext, bus.ENW}, {2'd1, 1'b0, 1'b0});
        end
        @(posedge clk); #1 bus.ext_valid = 1'b1;
        neg1();
        chk("load_go", {bus.Ext, bus.ENW, bus.Rin}, {1'b1, 1'b1, 2'd2});
        @(posedge clk); #1 bus.ext_valid = 1'b0;
        neg1();
        chk("load_done", {bus.inst_ready, bus.Ext}, {1'b1, 1'b0});

        // HALT with valid held, then reset
        issue(10'h00F, 1'b1);
        neg1();
        for (int i = 0; i < 5; i++) begin
            neg1();
            chk("halt_hold", {bus.halted, bus.inst_ready, bus.ENW, bus.ENR}, 4'b1000);
        end
        @(posedge clk); #3 rst_n = 1'b0; bus.inst_valid = 1'b0;
        neg1();
        chk("halt_rst", {bus.halted, bus.inst_ready, bus.err}, {1'b0, 1'b1, 1'b0});
        @(posedge clk); #3 rst_n = 1'b1;

        // Async reset inside SUB T2
        issue(10'h093, 1'b0);
        neg1();
        neg1();
        chk("sub_t2", {bus.T, bus.Gin}, {2'd2, 1'b1});
        rst_n = 1'b0;
        #1;
        chk("sub_abort", {bus.ENR, bus.Gin, bus.ENW, bus.T, bus.ALUcont}, 9'd0);
        neg1();
        chk("sub_abort_noenw", 32'(bus.ENW), 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        neg1();
        chk("sub_after", {bus.T, bus.inst_ready, bus.err}, {2'd0, 1'b1, 1'b0});

        // Randomized traffic; the model process checks every cycle
        hcnt = 0; done_pct = 25;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (c % 250 == 0) done_pct = (c / 250) % 3 == 0 ? 3 : ((c / 250) % 3 == 1 ? 25 : 60);
            bus.inst_in    = 10'($urandom);
            bus.inst_valid = ($urandom_range(0, 3) != 0);
            bus.ext_valid  = ($urandom_range(0, 2) == 0);
            bus.alu_done   = ($urandom_range(0, 99) < done_pct);
            #2;
            hcnt = bus.halted ? hcnt + 1 : 0;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 99) == 0 || hcnt > 4) rst_n = 1'b0;
        end
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seq_controller.md
Name: seq_controller

Overview:
Parametrised, self-sequencing successor to the combinational processor controller. It owns the instruction register and the timestep sequencer, which replace the external IR, T counter and Clr. It accepts instructions over a valid/ready handshake and supports multi-cycle ALU ops through a start/done handshake with a timeout. It drives the register file, the A/G latches, the ALU and the shared bus enables.

Parameters:
DATA_W, 10, instruction/data width; must be >= 4 + 2*RA_W
NUM_REGS, 4, register file depth; RA_W = $clog2(NUM_REGS), min 1
MULT_TIMEOUT, 15, max cycles spent in WAIT before abort; must be >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
inst_in  in  DATA_W  instruction word
inst_valid  in  1  inst_in valid
inst_ready  out  1  controller can accept an instruction
ext_valid  in  1  external data present on bus source
alu_done  in  1  multi-cycle ALU result ready
IMM  out  DATA_W  zero-extended immediate
Iout  out  1  drive IMM onto bus
Rin  out  RA_W  write address
Rout  out  RA_W  read address
ENW  out  1  register file write enable
ENR  out  1  register file read enable
Ain  out  1  latch A
Gin  out  1  latch G
Gout  out  1  drive G onto bus
ALUcont  out  4  ALU operation
Ext  out  1  drive external data onto bus
alu_start  out  1  one-cycle multi-cycle-op start pulse
T  out  2  current timestep (FETCH=0, T1=1, T2=2, T3/WAIT=3)
halted  out  1  HALT executed
err  out  1  sticky MULT timeout flag

Behaviour:
- Instruction fields: op=IR[3:0], Rx=IR[4+:RA_W], Ry=IR[4+RA_W+:RA_W], IMM=IR[DATA_W-1:4+RA_W] zero-extended.
- Opcodes: 0 LOAD, 1 COPY, 2 ADD, 3 SUB, 4 MULT, 5 INV, 6 FLP, 7 AND, 8 OR, 9 XOR, A ADDI, B SUBI, C SHL, D SHR, E NOP, F HALT.
- States: FETCH, T1, T2, T3, WAIT, HALTED. State and IR are registered. All outputs are combinational decodes of state+IR.
- Reset (async, rst_n=0): state=FETCH, IR=0, err=0, timeout count=0. All outputs are 0 except inst_ready=1 once in FETCH.
- FETCH: inst_ready=1. When inst_valid&inst_ready: IR<=inst_in, go T1. Otherwise stay.
- LOAD: T1 holds until ext_valid=1; in that cycle Ext=1, ENW=1, Rin=Rx; then FETCH.
- COPY: T1 asserts ENR=1, Rout=Ry, ENW=1, Rin=Rx; then FETCH.
- ADD/SUB/AND/OR/XOR:
  - T1: ENR, Rout=Rx, Ain.
  - T2: ENR, Rout=Ry, Gin, ALUcont=op.
  - T3: Gout, ENW, Rin=Rx; then FETCH.
- INV/FLP/SHL/SHR: as two-operand ops, but T2 has ENR=0 (no bus read).
- ADDI/SUBI: as two-operand ops, but T2 asserts Iout=1 and ENR=0. ALUcont=2 for ADDI, 3 for SUBI.
- MULT:
  - T1 as above.
  - T2: ENR, Rout=Ry, ALUcont=4, alu_start=1, Gin=0; go WAIT.
  - WAIT: ALUcont=4. When alu_done=1: Gin=1, go T3.
  - If MULT_TIMEOUT cycles elapse in WAIT with no done: err<=1, go FETCH with no writeback.
  - alu_done outside WAIT is ignored.
- NOP: T1 with no enables asserted, then FETCH.
- HALT: T1 goes to HALTED. HALTED: halted=1, inst_ready=0, all enables 0. Only reset exits.
- ALUcont=0 outside T2/WAIT. IMM reflects IR continuously. Iout gates its use.
- Throughput: 2 cycles for LOAD (with ext_valid), COPY and NOP; 4 cycles for ALU ops (FETCH+T1+T2+T3).
- Reset mid-instruction aborts immediately: no partial writeback and no further alu_start.

Test Plan:
- Reset then ADD R1,R2 (DATA_W=10, inst_in=0x092, valid held): IR latched. T1: Rout=1, Ain. T2: Rout=2, Gin, ALUcont=2. T3: Gout, ENW, Rin=1. inst_ready=1 in the next cycle.
- ADDI R3,#5 (0x17A): T2 has Iout=1, IMM=10'd5, ENR=0, ALUcont=2. T3 has Rin=3.
- MULT R0,R1 (0x044):
  - With alu_done after 3 WAIT cycles: alu_start is a single pulse in T2, Gin coincides with alu_done, then T3 writes Rin=0.
  - With alu_done withheld for 15 cycles: err=1, no ENW, return to FETCH.
- LOAD R2 (0x020) with ext_valid low for 4 cycles, then high: stays in T1 with Ext=0. Ext=ENW=1, Rin=2 in the ext_valid cycle only.
- HALT (0x00F): halted=1 and inst_ready=0 persist while inst_valid is held. rst_n pulse returns to FETCH with halted=0.
- Assert rst_n=0 asynchronously during T2 of SUB: all enables drop in the same cycle and no ENW occurs. After release: T=0, inst_ready=1, err=0.
